alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response/ALU bundle shared between two requesters and the arbiter
interface alu_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic [4:0]  req1_shamt;

  logic        resp0_valid, resp0_ready, resp0_zero, resp0_ovf;
  logic [31:0] resp0_data;
  logic        resp1_valid, resp1_ready, resp1_zero, resp1_ovf;
  logic [31:0] resp1_data;

  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shift;
  logic        alu_zero, alu_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp0_zero, resp0_ovf,
    output resp1_valid, resp1_data, resp1_zero, resp1_ovf,
    input  resp0_ready, resp1_ready,
    output alu_in1, alu_in2, alu_op, alu_shift,
    input  alu_out, alu_zero, alu_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp0_zero, resp0_ovf,
    input  resp1_valid, resp1_data, resp1_zero, resp1_ovf,
    output resp0_ready, resp1_ready,
    input  alu_in1, alu_in2, alu_op, alu_shift,
    output alu_out, alu_zero, alu_ovf
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two request/response ports
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d, gnt_q, gnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        zero_q, zero_d, ovf_q, ovf_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic        g0, g1, ovf_cap, resp_hs;

  always_comb begin
    g0      = bus.req0_valid && (!bus.req1_valid || !prio_q);
    g1      = bus.req1_valid && (!bus.req0_valid || prio_q);
    // overflow is only meaningful for add/sub; anything else may be a stale flag
    ovf_cap = bus.alu_ovf && ((op_q == 4'b0001) || (op_q == 4'b1010));
    resp_hs = gnt_q ? (v1_q && bus.resp1_ready) : (v0_q && bus.resp0_ready);

    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    v0_d    = v0_q;
    v1_d    = v1_q;

    case (state_q)
      IDLE: begin
        if (g0 || g1) begin
          gnt_d   = g1;
          a_d     = g1 ? bus.req1_a     : bus.req0_a;
          b_d     = g1 ? bus.req1_b     : bus.req0_b;
          op_d    = g1 ? bus.req1_op    : bus.req0_op;
          shamt_d = g1 ? bus.req1_shamt : bus.req0_shamt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_out;
        ovf_d   = ovf_cap;
        zero_d  = bus.alu_zero && (bus.alu_out == 32'd0) && !ovf_cap;
        v0_d    = !gnt_q;
        v1_d    = gnt_q;
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          v0_d    = 1'b0;
          v1_d    = 1'b0;
          prio_d  = !gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign bus.req0_ready  = (state_q == IDLE) && g0;
  assign bus.req1_ready  = (state_q == IDLE) && g1;

  assign bus.resp0_valid = v0_q;
  assign bus.resp0_data  = v0_q ? res_q : 32'd0;
  assign bus.resp0_zero  = v0_q && zero_q;
  assign bus.resp0_ovf   = v0_q && ovf_q;
  assign bus.resp1_valid = v1_q;
  assign bus.resp1_data  = v1_q ? res_q : 32'd0;
  assign bus.resp1_zero  = v1_q && zero_q;
  assign bus.resp1_ovf   = v1_q && ovf_q;

  assign bus.alu_in1   = a_q;
  assign bus.alu_in2   = b_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_shift = shamt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic clk;
  logic rst_n;
  logic stale_ovf;
  int   n_cmp;
  int   n_err;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU: add, sub, or, shift-left, anything else is in1 ^ 0xDEADBEEF
  logic [31:0] alu_r;
  always_comb begin
    alu_r = 32'd0;
    case (bus.alu_op)
      4'b0001: alu_r = bus.alu_in1 + bus.alu_in2;
      4'b1010: alu_r = bus.alu_in1 - bus.alu_in2;
      4'b0010: alu_r = bus.alu_in1 | bus.alu_in2;
      4'b0100: alu_r = bus.alu_in1 << bus.alu_shift;
      default: alu_r = bus.alu_in1 ^ 32'hDEADBEEF;
    endcase
    bus.alu_out  = alu_r;
    bus.alu_zero = (alu_r == 32'd0);
    if (bus.alu_op == 4'b0001)
      bus.alu_ovf = (bus.alu_in1[31] == bus.alu_in2[31]) && (alu_r[31] != bus.alu_in1[31]);
    else if (bus.alu_op == 4'b1010)
      bus.alu_ovf = (bus.alu_in1[31] != bus.alu_in2[31]) && (alu_r[31] != bus.alu_in1[31]);
    else
      bus.alu_ovf = stale_ovf;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [4:0] sh);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_shamt = sh;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [4:0] sh);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_shamt = sh;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    stale_ovf = 1'b0;
    rst_n = 1'b0;
    set_req0(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
    set_req1(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;

    tick();
    tick();
    chk("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
    chk("rst_alu_in1", bus.alu_in1, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_resp0_data", bus.resp0_data, 32'd0);
    rst_n = 1'b1;

    // single add 5+7, response valid for exactly one cycle
    set_req0(1'b1, 32'd5, 32'd7, 4'b0001, 5'd0);
    #1;
    chk("add_req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    chk("add_exec_valid", 32'(bus.resp0_valid), 32'd0);
    chk("add_exec_alu_in2", bus.alu_in2, 32'd7);
    tick();
    chk("add_valid", 32'(bus.resp0_valid), 32'd1);
    chk("add_data", bus.resp0_data, 32'd12);
    chk("add_zero", 32'(bus.resp0_zero), 32'd0);
    chk("add_ovf", 32'(bus.resp0_ovf), 32'd0);
    chk("add_resp_ready_blocked", 32'(bus.req0_ready), 32'd0);
    tick();
    chk("add_valid_one_cycle", 32'(bus.resp0_valid), 32'd0);

    // contention from reset release: strict alternation starting with req0
    rst_n = 1'b0;
    set_req0(1'b1, 32'd0, 32'd3, 4'b0001, 5'd0);
    set_req1(1'b1, 32'd100, 32'd0, 4'b1010, 5'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req0(1'b1, 32'(10 * k), 32'd3, 4'b0001, 5'd0);
      set_req1(1'b1, 32'd100, 32'(k), 4'b1010, 5'd0);
      #1;
      chk($sformatf("rr%0d_ready0", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_ready1", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
      tick();
      tick();
      if ((k % 2) == 0) begin
        chk($sformatf("rr%0d_valid0", k), 32'(bus.resp0_valid), 32'd1);
        chk($sformatf("rr%0d_valid1", k), 32'(bus.resp1_valid), 32'd0);
        chk($sformatf("rr%0d_data0", k), bus.resp0_data, 32'(10 * k + 3));
      end else begin
        chk($sformatf("rr%0d_valid1", k), 32'(bus.resp1_valid), 32'd1);
        chk($sformatf("rr%0d_valid0", k), 32'(bus.resp0_valid), 32'd0);
        chk($sformatf("rr%0d_data1", k), bus.resp1_data, 32'(100 - k));
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // overflow on add, then a stale overflow flag must not leak into an OR
    stale_ovf = 1'b1;
    set_req1(1'b1, 32'h7FFFFFFF, 32'd1, 4'b0001, 5'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("ovf_data", bus.resp1_data, 32'h80000000);
    chk("ovf_ovf", 32'(bus.resp1_ovf), 32'd1);
    chk("ovf_zero", 32'(bus.resp1_zero), 32'd0);
    tick();
    set_req1(1'b1, 32'd0, 32'd0, 4'b0010, 5'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("or_data", bus.resp1_data, 32'd0);
    chk("or_ovf_masked", 32'(bus.resp1_ovf), 32'd0);
    chk("or_zero", 32'(bus.resp1_zero), 32'd1);
    chk("or_other_port_valid", 32'(bus.resp0_valid), 32'd0);
    tick();
    stale_ovf = 1'b0;

    // backpressure on resp0 while req1 waits
    bus.resp0_ready = 1'b0;
    set_req0(1'b1, 32'd3, 32'd0, 4'b0100, 5'd4);
    set_req1(1'b1, 32'h12345678, 32'd0, 4'b1111, 5'd0);
    #1;
    chk("bp_ready0", 32'(bus.req0_ready), 32'd1);
    chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d_valid0", c), 32'(bus.resp0_valid), 32'd1);
      chk($sformatf("bp%0d_data0", c), bus.resp0_data, 32'h30);
      chk($sformatf("bp%0d_ready1", c), 32'(bus.req1_ready), 32'd0);
      tick();
    end
    bus.resp0_ready = 1'b1;
    #1;
    chk("bp_release_ready1_pre", 32'(bus.req1_ready), 32'd0);
    tick();
    chk("bp_release_ready1", 32'(bus.req1_ready), 32'd1);
    chk("bp_release_valid0", 32'(bus.resp0_valid), 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("undef_op_data1", bus.resp1_data, 32'hCC99E897);
    chk("undef_op_data0", bus.resp0_data, 32'd0);
    chk("undef_op_valid0", 32'(bus.resp0_valid), 32'd0);
    tick();

    // reset during EXEC aborts the sub
    set_req0(1'b1, 32'd9, 32'd4, 4'b1010, 5'd0);
    tick();
    bus.req0_valid = 1'b0;
    chk("mid_exec_alu_in1", bus.alu_in1, 32'd9);
    chk("mid_exec_alu_op", 32'(bus.alu_op), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_in1", bus.alu_in1, 32'd0);
    chk("mid_rst_alu_in2", bus.alu_in2, 32'd0);
    chk("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort%0d_valid0", c), 32'(bus.resp0_valid), 32'd0);
      chk($sformatf("abort%0d_data0", c), bus.resp0_data, 32'd0);
      tick();
    end
    set_req0(1'b1, 32'd9, 32'd4, 4'b1010, 5'd0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("fresh_valid", 32'(bus.resp0_valid), 32'd1);
    chk("fresh_data", bus.resp0_data, 32'd5);
    chk("fresh_ovf", 32'(bus.resp0_ovf), 32'd0);
    tick();
    chk("fresh_done", 32'(bus.resp0_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
